// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment capture path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: segment width, the active-low hex pattern table (same table the
// hex-to-segment ROM drives), and the capture FSM state encoding.
package sseg_pkg;

    localparam int SEG_W = 7;

    // Active-low {a,b,c,d,e,f,g} pattern for each hex digit, indexed by digit value.
    localparam logic [SEG_W-1:0] SEG_PAT [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_HOLD   = 2'd2
    } cap_state_t;

endpackage

// File: rtl/sseg_pattern_decode.sv
// Reverse lookup of an active-low 7-segment pattern to its hex nibble.
// Latency: combinational.
// Backpressure: none.
// Ports: i_pat segment pattern in; o_hit pattern is a known digit; o_nib digit value.
module sseg_pattern_decode
    import sseg_pkg::*;
(
    input  logic [SEG_W-1:0] i_pat,
    output logic             o_hit,
    output logic [3:0]       o_nib
);

    always_comb begin
        o_hit = 1'b0;
        o_nib = 4'h0;
        for (int k = 0; k < 16; k++) begin
            if (i_pat == SEG_PAT[k]) begin
                o_hit = 1'b1;
                o_nib = 4'(k);
            end
        end
    end

endmodule

// File: rtl/sseg_scan_capture.sv
// Recovers hex digits and decimal points from a multiplexed active-low display bus.
// Latency: hex/dp update SETTLE+3 edges after the last an/sseg change; frame_done one edge later.
// Backpressure: none; passive tap, a dwell shorter than SETTLE+1 cycles is ignored.
// Ports: clk/reset_n; an, sseg display nets in; err_clr clears err;
//        hex/dp captured digits, frame_done per full scan, err/err_pat unknown pattern.
module sseg_scan_capture
    import sseg_pkg::*;
#(
    parameter int N_DIG  = 4,
    parameter int SETTLE = 8
)(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_DIG-1:0]     an,
    input  logic [7:0]           sseg,
    input  logic                 err_clr,
    output logic [4*N_DIG-1:0]   hex,
    output logic [N_DIG-1:0]     dp,
    output logic                 frame_done,
    output logic                 err,
    output logic [SEG_W-1:0]     err_pat
);

    logic [N_DIG-1:0]   r_an_s1, r_an_s2, r_an_prev;
    logic [7:0]         r_sseg_s1, r_sseg_s2, r_sseg_prev;
    logic [7:0]         r_stable_cnt;
    cap_state_t         r_state;
    logic [4*N_DIG-1:0] r_hex;
    logic [N_DIG-1:0]   r_dp;
    logic [N_DIG-1:0]   r_seen;
    logic               r_frame_done;
    logic               r_err;
    logic [SEG_W-1:0]   r_err_pat;

    logic               w_chg;
    logic [N_DIG-1:0]   w_sel;
    logic               w_trig;
    logic               w_hit;
    logic [3:0]         w_nib;

    sseg_pattern_decode u_dec (
        .i_pat (r_sseg_s2[SEG_W-1:0]),
        .o_hit (w_hit),
        .o_nib (w_nib)
    );

    assign w_chg = (r_an_s2 != r_an_prev) || (r_sseg_s2 != r_sseg_prev);
    assign w_sel = ~r_an_s2;
    // The !w_chg term stops a dwell of exactly SETTLE cycles from sampling the
    // value that has just replaced it.
    assign w_trig = (r_state == ST_WAIT) && !w_chg &&
                    (r_stable_cnt == 8'(SETTLE - 1)) && $onehot(w_sel);

    // Synchroniser, previous-value register and settle counter. Reset to the
    // idle (all ones) bus value so a held digit still needs a full window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_an_s1      <= '1;
            r_an_s2      <= '1;
            r_an_prev    <= '1;
            r_sseg_s1    <= '1;
            r_sseg_s2    <= '1;
            r_sseg_prev  <= '1;
            r_stable_cnt <= '0;
        end else begin
            r_an_s1     <= an;
            r_an_s2     <= r_an_s1;
            r_an_prev   <= r_an_s2;
            r_sseg_s1   <= sseg;
            r_sseg_s2   <= r_sseg_s1;
            r_sseg_prev <= r_sseg_s2;
            if (w_chg)
                r_stable_cnt <= '0;
            else if (r_stable_cnt != 8'hFF)
                r_stable_cnt <= r_stable_cnt + 8'd1;
        end
    end

    // Capture FSM. The capture itself is registered on the WAIT->SAMPLE edge,
    // so SAMPLE is the first cycle with the new digit visible; HOLD then
    // blocks further captures until the bus moves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_WAIT;
            r_hex        <= '0;
            r_dp         <= '0;
            r_seen       <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_err_pat    <= '0;
        end else begin
            case (r_state)
                ST_WAIT:   if (w_trig) r_state <= ST_SAMPLE;
                ST_SAMPLE: r_state <= w_chg ? ST_WAIT : ST_HOLD;
                ST_HOLD:   if (w_chg) r_state <= ST_WAIT;
                default:   r_state <= ST_WAIT;
            endcase

            r_frame_done <= &r_seen;
            r_seen <= ((&r_seen) ? '0 : r_seen) | ((w_trig && w_hit) ? w_sel : '0);

            for (int i = 0; i < N_DIG; i++) begin
                if (w_trig && w_hit && w_sel[i]) begin
                    r_hex[4*i +: 4] <= w_nib;
                    r_dp[i]         <= ~r_sseg_s2[7];
                end
            end

            // A miss in the same cycle as err_clr leaves err set.
            if (w_trig && !w_hit) begin
                r_err     <= 1'b1;
                r_err_pat <= r_sseg_s2[SEG_W-1:0];
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign hex        = r_hex;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;
    assign err        = r_err;
    assign err_pat    = r_err_pat;

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed bench for sseg_scan_capture: latency, scan, errors, glitch rejection, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_sseg_scan_capture;
    import sseg_pkg::*;

    localparam int N_DIG  = 4;
    localparam int SETTLE = 8;

    logic               clk;
    logic               reset_n;
    logic [N_DIG-1:0]   an;
    logic [7:0]         sseg;
    logic               err_clr;
    logic [4*N_DIG-1:0] hex;
    logic [N_DIG-1:0]   dp;
    logic               frame_done;
    logic               err;
    logic [SEG_W-1:0]   err_pat;

    int n_cmp = 0;
    int n_err = 0;
    int fd_cnt = 0;
    int fd0;

    sseg_scan_capture #(.N_DIG(N_DIG), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .an         (an),
        .sseg       (sseg),
        .err_clr    (err_clr),
        .hex        (hex),
        .dp         (dp),
        .frame_done (frame_done),
        .err        (err),
        .err_pat    (err_pat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done) fd_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dwell(input logic [N_DIG-1:0] a, input logic [7:0] s, input int n);
        an   = a;
        sseg = s;
        run(n);
    endtask

    initial begin
        reset_n = 1'b0;
        an      = '1;
        sseg    = 8'hFF;
        err_clr = 1'b0;
        run(3);
        chk("rst_hex", 32'(hex), 32'h0);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_errpat", 32'(err_pat), 32'h0);
        reset_n = 1'b1;
        run(5);

        // Single digit '1', dp off, exact capture latency.
        an = 4'b1110; sseg = 8'hCF;
        run(SETTLE + 2);
        chk("lat_pre_hex", 32'(hex), 32'h0);
        run(1);
        chk("lat_hex", 32'(hex), 32'h0001);
        chk("lat_dp", 32'(dp), 32'h0);
        chk("lat_err", 32'(err), 32'h0);
        run(9);

        // Full scan A,B,C,D with dp on digit 2.
        fd0 = fd_cnt;
        dwell(4'b1110, 8'h88, 12);
        dwell(4'b1101, 8'hE0, 12);
        dwell(4'b1011, 8'h31, 12);
        an = 4'b0111; sseg = 8'hC2;
        run(SETTLE + 3);
        chk("scan_hex", 32'(hex), 32'hDCBA);
        chk("scan_fd_pre", 32'(frame_done), 32'h0);
        run(1);
        chk("scan_fd", 32'(frame_done), 32'h1);
        dwell(4'b1111, 8'hFF, 20);
        chk("scan_fd_cnt", 32'(fd_cnt - fd0), 32'h1);
        chk("scan_dp", 32'(dp), 32'h4);

        // Unknown pattern then clear.
        dwell(4'b1110, 8'hFF, 12);
        chk("miss_err", 32'(err), 32'h1);
        chk("miss_pat", 32'(err_pat), 32'h7F);
        chk("miss_hex", 32'(hex), 32'hDCBA);
        err_clr = 1'b1; run(1); err_clr = 1'b0;
        chk("clr_err", 32'(err), 32'h0);

        // Short dwell, overlap, blanking, SETTLE vs SETTLE+1 boundary.
        fd0 = fd_cnt;
        dwell(4'b1101, 8'h81, 5);
        dwell(4'b1111, 8'h81, 20);
        chk("short_hex", 32'(hex), 32'hDCBA);
        dwell(4'b1100, 8'h81, 20);
        chk("overlap_hex", 32'(hex), 32'hDCBA);
        dwell(4'b1111, 8'h81, 20);
        chk("blank_hex", 32'(hex), 32'hDCBA);
        chk("glitch_err", 32'(err), 32'h0);
        dwell(4'b1101, 8'h81, SETTLE);
        dwell(4'b1111, 8'hFF, 20);
        chk("dwell8_hex", 32'(hex), 32'hDCBA);
        dwell(4'b1101, 8'h81, SETTLE + 1);
        dwell(4'b1111, 8'hFF, 20);
        chk("dwell9_hex", 32'(hex), 32'hDC0A);
        chk("glitch_fd", 32'(fd_cnt - fd0), 32'h0);

        // Reset in the middle of a scan.
        dwell(4'b1110, 8'h86, 12);
        dwell(4'b1101, 8'hA4, 12);
        an = 4'b1011; sseg = 8'h8F;
        run(4);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_hex", 32'(hex), 32'h0);
        chk("mid_rst_dp", 32'(dp), 32'h0);
        chk("mid_rst_fd", 32'(frame_done), 32'h0);
        chk("mid_rst_err", 32'(err), 32'h0);
        chk("mid_rst_errpat", 32'(err_pat), 32'h0);
        run(1);
        reset_n = 1'b1;
        fd0 = fd_cnt;
        dwell(4'b1110, 8'h86, 12);
        dwell(4'b1101, 8'hA4, 12);
        dwell(4'b1011, 8'h8F, 12);
        dwell(4'b0111, 8'h84, 12);
        dwell(4'b1111, 8'hFF, 20);
        chk("post_rst_hex", 32'(hex), 32'h9753);
        chk("post_rst_dp", 32'(dp), 32'h0);
        chk("post_rst_fd", 32'(fd_cnt - fd0), 32'h1);

        // Miss on the last outstanding digit, coincident with err_clr.
        fd0 = fd_cnt;
        dwell(4'b1110, 8'h86, 12);
        dwell(4'b1101, 8'hA4, 12);
        dwell(4'b1011, 8'h8F, 12);
        an = 4'b0111; sseg = 8'hD5;
        run(SETTLE + 2);
        chk("coin_pre_err", 32'(err), 32'h0);
        err_clr = 1'b1; run(1); err_clr = 1'b0;
        chk("coin_err", 32'(err), 32'h1);
        chk("coin_pat", 32'(err_pat), 32'h55);
        run(10);
        chk("coin_err_hold", 32'(err), 32'h1);
        chk("coin_no_fd", 32'(fd_cnt - fd0), 32'h0);
        chk("coin_hex", 32'(hex), 32'h9753);
        err_clr = 1'b1; run(1); err_clr = 1'b0;
        chk("final_clr", 32'(err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
